// File: rtl/fp_int_pkg.sv
// Shared FP16 field layout, state encoding and guard widths for the
// bit-serial FP16 x INT dot-product engine.
package fp_int_pkg;

  localparam int EXP_W       = 5;
  localparam int MAN_W       = 10;
  localparam int SIG_W       = MAN_W + 1;
  localparam int SIGN_POS    = EXP_W + MAN_W;
  localparam int PREC_W      = 4;
  // Extra headroom so a product shifted left by up to 31 never wraps before saturation.
  localparam int SHIFT_GUARD = 32;
  localparam logic [EXP_W-1:0] EXP_NAN_INF = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [EXP_W-1:0] fp16_exp(input logic [15:0] a);
    return a[SIGN_POS-1 -: EXP_W];
  endfunction

  // Hidden bit is 1 for normals and 0 for subnormals.
  function automatic logic [SIG_W-1:0] fp16_sig(input logic [15:0] a);
    return {(a[SIGN_POS-1 -: EXP_W] != '0), a[MAN_W-1:0]};
  endfunction

endpackage

// File: rtl/fp_int_lane_term.sv
// One dot-product lane: builds sig*W one weight bit per beat, then applies
// the activation sign, aligns to the block exponent and saturates.
module fp_int_lane_term
  import fp_int_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_PREC  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_beat_en,
  input  logic                 i_first,
  input  logic                 i_neg,
  input  logic [PREC_W-1:0]    i_bit_idx,
  input  logic [ACT_WIDTH-1:0] i_act,
  input  logic                 i_w,
  input  logic [EXP_W-1:0]     i_exp_b,
  output logic [ACC_WIDTH-1:0] o_term,
  output logic                 o_sat,
  output logic                 o_nan
);

  localparam int PP_W  = SIG_W + MAX_PREC + 1;
  localparam int EXT_W = PP_W + SHIFT_GUARD;

  logic [ACT_WIDTH-1:0]     r_act;
  logic signed [PP_W-1:0]   r_pp;
  logic [SIG_W-1:0]         w_sig_now;
  logic signed [PP_W-1:0]   w_base;
  logic signed [PP_W-1:0]   w_add;
  logic [EXP_W-1:0]         w_exp;
  logic [EXP_W-1:0]         w_ee;
  logic signed [PP_W-1:0]   w_prod;
  logic signed [EXT_W-1:0]  w_ext;
  logic signed [EXT_W-1:0]  w_shifted;
  logic [EXT_W-ACC_WIDTH:0] w_hi;

  // Beat 0 uses the activation on the bus since it is only captured at that edge.
  always_comb begin
    w_sig_now = i_first ? fp16_sig(i_act) : fp16_sig(r_act);
    w_base    = i_first ? '0 : r_pp;
    w_add     = {{(PP_W-SIG_W){1'b0}}, w_sig_now} << i_bit_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act <= '0;
      r_pp  <= '0;
    end else if (i_beat_en) begin
      if (i_first) begin
        r_act <= i_act;
      end
      if (i_w) begin
        r_pp <= i_neg ? (w_base - w_add) : (w_base + w_add);
      end else begin
        r_pp <= w_base;
      end
    end
  end

  always_comb begin
    w_exp  = fp16_exp(r_act);
    w_ee   = (w_exp == '0) ? EXP_W'(1) : w_exp;
    w_prod = r_act[SIGN_POS] ? -r_pp : r_pp;
    w_ext  = {{SHIFT_GUARD{w_prod[PP_W-1]}}, w_prod};
    if (w_ee > i_exp_b) begin
      w_shifted = w_ext <<< (w_ee - i_exp_b);
    end else begin
      w_shifted = w_ext >>> (i_exp_b - w_ee);
    end
    w_hi   = w_shifted[EXT_W-1:ACC_WIDTH-1];
    o_nan  = (w_exp == EXP_NAN_INF);
    o_sat  = 1'b0;
    o_term = w_shifted[ACC_WIDTH-1:0];
    if (o_nan) begin
      o_term = '0;
    end else if (!((&w_hi) || !(|w_hi))) begin
      o_sat  = 1'b1;
      o_term = w_shifted[EXT_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fp_int_dot_serial.sv
// LANES-wide FP16 x bit-serial integer dot product accumulated over a run-time
// number of vectors into a saturating fixed-point accumulator.
module fp_int_dot_serial
  import fp_int_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_PREC  = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [PREC_W-1:0]          precision,
  input  logic                       w_signed,
  input  logic [LEN_WIDTH-1:0]       len,
  input  logic [EXP_W-1:0]           exp_set,
  input  logic [ACC_WIDTH-1:0]       acc_init,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*ACT_WIDTH-1:0] act,
  input  logic [LANES-1:0]           w,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W-1:0]           exp_out,
  output logic [ACC_WIDTH-1:0]       acc_out,
  output logic                       ovf,
  output logic                       nan_inf,
  output logic                       valid_fwd,
  output logic [LANES*ACT_WIDTH-1:0] act_fwd,
  output logic [LANES-1:0]           w_fwd,
  output state_e                     dbg_state
);

  localparam int SUM_W = ACC_WIDTH + $clog2(LANES + 1) + 1;
  localparam int GUARD = SUM_W - ACC_WIDTH;
  localparam logic [PREC_W-1:0] MAX_P = PREC_W'(MAX_PREC);

  state_e                 r_state;
  state_e                 w_next;
  logic [PREC_W-1:0]      r_prec;
  logic                   r_wsigned;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [EXP_W-1:0]       r_exp;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_ovf;
  logic                   r_nan;
  logic [PREC_W-1:0]      r_beat;
  logic [LEN_WIDTH-1:0]   r_vcnt;

  logic [PREC_W-1:0]      w_prec_eff;
  logic                   w_accept;
  logic                   w_first;
  logic                   w_last;
  logic                   w_neg;
  logic [LEN_WIDTH-1:0]   w_vcnt_next;
  logic [ACC_WIDTH-1:0]   w_term [LANES];
  logic [LANES-1:0]       w_sat;
  logic [LANES-1:0]       w_nan;
  logic [SUM_W-1:0]       w_sum;
  logic [GUARD:0]         w_hi;
  logic                   w_clamp;
  logic [ACC_WIDTH-1:0]   w_acc_next;

  // Handshake: a beat (act, w) transfers on a clock edge where in_valid && in_ready;
  // the result transfers on an edge where out_valid && out_ready, and is held until then.
  always_comb begin
    w_accept    = in_valid && in_ready;
    w_first     = (r_beat == '0);
    w_last      = (r_beat == (r_prec - PREC_W'(1)));
    w_neg       = w_last && r_wsigned;
    w_vcnt_next = r_vcnt + LEN_WIDTH'(1);
    if (precision == '0) begin
      w_prec_eff = PREC_W'(1);
    end else if (precision > MAX_P) begin
      w_prec_eff = MAX_P;
    end else begin
      w_prec_eff = precision;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (w_accept && w_last) w_next = S_ACCUM;
      S_ACCUM: w_next = (w_vcnt_next == r_len) ? S_DONE : S_LOAD;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_LOAD);
    out_valid = (r_state == S_DONE);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_int_lane_term #(
      .ACT_WIDTH (ACT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .MAX_PREC  (MAX_PREC)
    ) u_lane (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_beat_en (w_accept),
      .i_first   (w_first),
      .i_neg     (w_neg),
      .i_bit_idx (r_beat),
      .i_act     (act[g*ACT_WIDTH +: ACT_WIDTH]),
      .i_w       (w[g]),
      .i_exp_b   (r_exp),
      .o_term    (w_term[g]),
      .o_sat     (w_sat[g]),
      .o_nan     (w_nan[g])
    );
  end

  // Sum is wide enough that LANES saturated terms plus acc cannot wrap.
  always_comb begin
    w_sum = {{GUARD{r_acc[ACC_WIDTH-1]}}, r_acc};
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + {{GUARD{w_term[i][ACC_WIDTH-1]}}, w_term[i]};
    end
    w_hi    = w_sum[SUM_W-1:ACC_WIDTH-1];
    w_clamp = !((&w_hi) || !(|w_hi));
    if (!w_clamp) begin
      w_acc_next = w_sum[ACC_WIDTH-1:0];
    end else if (w_sum[SUM_W-1]) begin
      w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prec    <= '0;
      r_wsigned <= 1'b0;
      r_len     <= '0;
      r_exp     <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_nan     <= 1'b0;
      r_beat    <= '0;
      r_vcnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_prec    <= w_prec_eff;
            r_wsigned <= w_signed;
            r_len     <= len;
            r_exp     <= exp_set;
            r_acc     <= acc_init;
            r_ovf     <= 1'b0;
            r_nan     <= 1'b0;
            r_beat    <= '0;
            r_vcnt    <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_beat <= w_last ? '0 : (r_beat + PREC_W'(1));
          end
        end
        S_ACCUM: begin
          r_acc  <= w_acc_next;
          r_ovf  <= r_ovf | w_clamp | (|w_sat);
          r_nan  <= r_nan | (|w_nan);
          r_vcnt <= w_vcnt_next;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_fwd <= 1'b0;
      act_fwd   <= '0;
      w_fwd     <= '0;
    end else begin
      valid_fwd <= w_accept;
      if (w_accept) begin
        act_fwd <= act;
        w_fwd   <= w;
      end
    end
  end

  assign acc_out   = r_acc;
  assign exp_out   = r_exp;
  assign ovf       = r_ovf;
  assign nan_inf   = r_nan;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_int_dot_serial.sv
// Bench for fp_int_dot_serial: directed cases plus randomized dot products
// checked by a reference model through an expected-result queue.
module tb_fp_int_dot_serial;
  import fp_int_pkg::*;

  localparam int LANES     = 4;
  localparam int ACT_WIDTH = 16;
  localparam int ACC_WIDTH = 32;
  localparam int MAX_PREC  = 8;
  localparam int LEN_WIDTH = 8;
  localparam int AW        = LANES * ACT_WIDTH;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_WIDTH - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_WIDTH - 1));

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [3:0]           precision;
  logic                 w_signed;
  logic [LEN_WIDTH-1:0] len;
  logic [4:0]           exp_set;
  logic [ACC_WIDTH-1:0] acc_init;
  logic                 in_valid;
  logic                 in_ready;
  logic [AW-1:0]        act;
  logic [LANES-1:0]     w;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           exp_out;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 ovf;
  logic                 nan_inf;
  logic                 valid_fwd;
  logic [AW-1:0]        act_fwd;
  logic [LANES-1:0]     w_fwd;
  state_e               dbg_state;

  fp_int_dot_serial #(
    .LANES(LANES), .ACT_WIDTH(ACT_WIDTH), .ACC_WIDTH(ACC_WIDTH),
    .MAX_PREC(MAX_PREC), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .precision(precision),
    .w_signed(w_signed), .len(len), .exp_set(exp_set), .acc_init(acc_init),
    .in_valid(in_valid), .in_ready(in_ready), .act(act), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
    .acc_out(acc_out), .ovf(ovf), .nan_inf(nan_inf), .valid_fwd(valid_fwd),
    .act_fwd(act_fwd), .w_fwd(w_fwd), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [ACC_WIDTH-1:0] exp_acc_q[$];
  logic [4:0]           exp_e_q[$];
  logic [0:0]           exp_ovf_q[$];
  logic [0:0]           exp_nan_q[$];

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [ACC_WIDTH-1:0] a, input logic [4:0] e,
                          input bit o, input bit n);
    exp_acc_q.push_back(a);
    exp_e_q.push_back(e);
    exp_ovf_q.push_back(o);
    exp_nan_q.push_back(n);
  endtask

  // ---------------- reference model ----------------
  // Value of FP16 a times integer wv, expressed in units of 2^(eb-25).
  function automatic longint lane_term(input logic [15:0] a, input int wv, input int eb,
                                       inout bit sat, inout bit nan);
    int e, m, ee;
    longint sig, prod, t;
    e = int'(a[14:10]);
    m = int'(a[9:0]);
    sig = (e != 0) ? longint'(1024 + m) : longint'(m);
    ee = (e == 0) ? 1 : e;
    prod = sig * longint'(wv);
    if (a[15]) prod = -prod;
    if (e == 31) begin
      nan = 1'b1;
      return 0;
    end
    if (ee <= eb) t = prod >>> (eb - ee);
    else t = prod * (longint'(1) <<< (ee - eb));
    if (t > ACC_MAX) begin t = ACC_MAX; sat = 1'b1; end
    else if (t < ACC_MIN) begin t = ACC_MIN; sat = 1'b1; end
    return t;
  endfunction

  longint mdl_acc;
  bit     mdl_ovf, mdl_nan, op_manual;
  int     op_p, op_len, op_vecs, op_eb;
  int     cur_w [LANES];
  bit     stall_all, stall_rand;

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int g = 0;
    while (dbg_state != S_IDLE && g < 300) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 300) check("idle_timeout", 1, 0);
  endtask

  task automatic start_op(input int prec_in, input bit sgn, input int n,
                          input int eb, input logic [ACC_WIDTH-1:0] init, input bit manual);
    op_p      = (prec_in == 0) ? 1 : ((prec_in > MAX_PREC) ? MAX_PREC : prec_in);
    op_len    = n;
    op_vecs   = 0;
    op_eb     = eb;
    op_manual = manual;
    mdl_acc   = longint'($signed(init));
    mdl_ovf   = 1'b0;
    mdl_nan   = 1'b0;
    start     = 1'b1;
    precision = 4'(prec_in);
    w_signed  = sgn;
    len       = LEN_WIDTH'(n);
    exp_set   = 5'(eb);
    acc_init  = init;
    @(posedge clk); #1;
    start     = 1'b0;
    precision = 4'($urandom);
    len       = LEN_WIDTH'($urandom);
    exp_set   = 5'($urandom);
    acc_init  = $urandom;
    if (!manual && n == 0) push_exp(init, 5'(eb), 1'b0, 1'b0);
  endtask

  task automatic drive_beat(input logic [AW-1:0] a, input logic [LANES-1:0] wb);
    bit rdy;
    int g = 0;
    if (stall_all || (stall_rand && $urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      act      = {$urandom, $urandom};
      w        = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    act      = a;
    w        = wb;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      g++;
    end while (!rdy && g < 50);
    if (!rdy) check("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_vector(input logic [AW-1:0] a);
    longint sum;
    bit sat, nan;
    logic [LANES-1:0] wb;
    logic [AW-1:0] garbage;
    sat = 1'b0;
    nan = 1'b0;
    sum = mdl_acc;
    for (int l = 0; l < LANES; l++) sum += lane_term(a[l*16 +: 16], cur_w[l], op_eb, sat, nan);
    if (sum > ACC_MAX) begin sum = ACC_MAX; sat = 1'b1; end
    else if (sum < ACC_MIN) begin sum = ACC_MIN; sat = 1'b1; end
    mdl_acc = sum;
    mdl_ovf = mdl_ovf | sat;
    mdl_nan = mdl_nan | nan;
    for (int b = 0; b < op_p; b++) begin
      for (int l = 0; l < LANES; l++) wb[l] = cur_w[l][b];
      garbage = {$urandom, $urandom};
      drive_beat((b == 0) ? a : garbage, wb);
    end
    op_vecs++;
    if (!op_manual && op_vecs == op_len)
      push_exp(mdl_acc[ACC_WIDTH-1:0], 5'(op_eb), mdl_ovf, mdl_nan);
  endtask

  task automatic run_directed(input int prec_in, input bit sgn, input int eb,
                              input logic [ACC_WIDTH-1:0] init, input logic [AW-1:0] a,
                              input int w0, input int w1, input int w2, input int w3,
                              input logic [ACC_WIDTH-1:0] want_acc, input bit want_ovf,
                              input bit want_nan, input bit lat);
    wait_idle();
    start_op(prec_in, sgn, 1, eb, init, 1'b1);
    cur_w[0] = w0; cur_w[1] = w1; cur_w[2] = w2; cur_w[3] = w3;
    send_vector(a);
    push_exp(want_acc, 5'(eb), want_ovf, want_nan);
    if (lat) begin
      @(negedge clk);
      check("lat_accum_out_valid", longint'(out_valid), 0);
      @(negedge clk);
      check("lat_done_out_valid", longint'(out_valid), 1);
    end
  endtask

  function automatic logic [15:0] rand_act();
    int sel;
    logic [4:0] e;
    sel = $urandom_range(0, 15);
    if (sel == 0) e = 5'd0;
    else if (sel == 1) e = 5'd31;
    else if (sel == 2) e = 5'd30;
    else e = 5'($urandom_range(8, 22));
    return {1'($urandom_range(0, 1)), e, 10'($urandom)};
  endfunction

  // ---------------- result consumer and monitor ----------------
  always @(posedge clk) begin
    #1 out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_acc_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got acc 0x%0h with no result pending", acc_out);
      end else begin
        check("acc_out", longint'(acc_out), longint'(exp_acc_q.pop_front()));
        check("exp_out", longint'(exp_out), longint'(exp_e_q.pop_front()));
        check("ovf", longint'(ovf), longint'(exp_ovf_q.pop_front()));
        check("nan_inf", longint'(nan_inf), longint'(exp_nan_q.pop_front()));
      end
    end
  end

  // Forwarding registers must repeat each accepted beat exactly one cycle later.
  bit            pend_v;
  logic [AW-1:0] pend_act;
  logic [3:0]    pend_w;
  always @(negedge clk) begin
    if (!rst) begin
      pend_v = 1'b0;
    end else begin
      check("valid_fwd", longint'(valid_fwd), longint'(pend_v));
      if (pend_v) begin
        check("act_fwd", longint'(act_fwd), longint'(pend_act));
        check("w_fwd", longint'(w_fwd), longint'(pend_w));
      end
      pend_v   = in_valid && in_ready;
      pend_act = act;
      pend_w   = w;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, eb, pi, p;
    bit sgn;
    logic [ACC_WIDTH-1:0] init;
    rst = 1'b0; start = 1'b0; precision = '0; w_signed = 1'b0; len = '0;
    exp_set = '0; acc_init = '0; in_valid = 1'b0; act = '0; w = '0; out_ready = 1'b0;
    stall_all = 1'b0; stall_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_acc_out", longint'(acc_out), 0);
    check("rst_exp_out", longint'(exp_out), 0);
    check("rst_flags", longint'({ovf, nan_inf}), 0);
    check("rst_fwd", longint'({valid_fwd, w_fwd}), 0);
    check("rst_act_fwd", longint'(act_fwd), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1.0 x {3,-2,5,1} = 7 -> 7*1024, with result two cycles after the last beat
    run_directed(4, 1, 15, 32'd0, {4{16'h3C00}}, 3, -2, 5, 1, 32'd7168, 0, 0, 1);
    // 2.0 + 0.5 with unit weights
    run_directed(4, 1, 15, 32'd0, {16'h0, 16'h0, 16'h3800, 16'h4000}, 1, 1, 1, 1, 32'd2560, 0, 0, 0);
    // Weight bits 1111: 15 unsigned, -1 signed
    run_directed(4, 0, 15, 32'd0, {16'h0, 16'h0, 16'h0, 16'h3C00}, 15, 0, 0, 0, 32'd15360, 0, 0, 0);
    run_directed(4, 1, 15, 32'd0, {16'h0, 16'h0, 16'h0, 16'h3C00}, -1, 0, 0, 0, 32'hFFFF_FC00, 0, 0, 0);
    // Accumulator clamps at both ends
    run_directed(4, 1, 15, 32'h7FFF_FF00, {16'h0, 16'h0, 16'h0, 16'h3C00}, 1, 0, 0, 0, 32'h7FFF_FFFF, 1, 0, 0);
    run_directed(4, 1, 15, 32'h8000_0100, {16'h0, 16'h0, 16'h0, 16'h3C00}, -1, 0, 0, 0, 32'h8000_0000, 1, 0, 0);
    // Lane term 1024<<30 saturates by itself
    run_directed(1, 0, 0, 32'd0, {16'h0, 16'h0, 16'h0, 16'h7800}, 1, 0, 0, 0, 32'h7FFF_FFFF, 1, 0, 0);
    // NaN lane contributes zero and raises nan_inf
    run_directed(4, 1, 15, 32'd0, {16'h0, 16'h0, 16'h3C00, 16'h7E00}, 1, 1, 1, 1, 32'd1024, 0, 1, 0);
    // Subnormal 0x0001 at E_b=1: sig 1 * 3 = 3
    run_directed(2, 0, 1, 32'd0, {16'h0, 16'h0, 16'h0, 16'h0001}, 3, 0, 0, 0, 32'd3, 0, 0, 0);
    // Precision 0 acts as 1 bit; precision 12 acts as 8 bits (weight 200)
    run_directed(0, 0, 15, 32'd10, {16'h0, 16'h0, 16'h0, 16'h3C00}, 1, 0, 0, 0, 32'd1034, 0, 0, 0);
    run_directed(12, 0, 15, 32'd0, {16'h0, 16'h0, 16'h0, 16'h3C00}, 200, 0, 0, 0, 32'd204800, 0, 0, 0);
    // Stalls before every beat change nothing
    stall_all = 1'b1;
    run_directed(4, 1, 15, 32'd0, {16'h0, 16'h0, 16'h3800, 16'h4000}, 1, 1, 1, 1, 32'd2560, 0, 0, 0);
    stall_all = 1'b0;

    // Reset in the middle of LOAD abandons the operation
    wait_idle();
    start_op(4, 1, 2, 15, 32'd99, 1'b1);
    drive_beat({4{16'h3C00}}, 4'hF);
    drive_beat({4{16'h3C00}}, 4'h5);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_acc_out", longint'(acc_out), 0);
    check("midrst_valid_fwd", longint'(valid_fwd), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("postrst_state", longint'(dbg_state), longint'(S_IDLE));
    start_op(4, 0, 0, 7, 32'd5, 1'b1);
    push_exp(32'd5, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    check("len0_out_valid", longint'(out_valid), 1);

    // Randomized dot products
    stall_rand = 1'b1;
    for (int op = 0; op < 14; op++) begin
      pi  = $urandom_range(0, 10);
      sgn = 1'($urandom_range(0, 1));
      n   = $urandom_range(0, 3);
      eb  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(10, 20);
      init = $urandom_range(0, 200000);
      if ($urandom_range(0, 1) == 1) init = -init;
      if ($urandom_range(0, 7) == 0) init = $urandom;
      wait_idle();
      start_op(pi, sgn, n, eb, init, 1'b0);
      p = op_p;
      for (int v = 0; v < n; v++) begin
        for (int l = 0; l < LANES; l++) begin
          if (sgn) cur_w[l] = $urandom_range(0, (1 << p) - 1) - (1 << (p - 1));
          else cur_w[l] = $urandom_range(0, (1 << p) - 1);
        end
        send_vector({rand_act(), rand_act(), rand_act(), rand_act()});
      end
    end

    begin
      int g = 0;
      while (exp_acc_q.size() != 0 && g < 500) begin
        @(posedge clk); g++;
      end
    end
    check("results_drained", longint'(exp_acc_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_int_dot_serial.md
Name: fp_int_dot_serial

Overview:
- Parametrised successor to the single-lane FP16×INT bit-serial MAC.
- Computes a LANES-wide dot product of FP16 activations and bit-serial integer weights; weight precision (1..MAX_PREC) and signedness are selected at run time.
- Accumulates a run-time length of vectors into one saturating fixed-point accumulator at a block exponent.
- Forwards registered act/weight/valid for systolic chaining.

Parameters:
- LANES, 4, parallel activation/weight channels.
- ACT_WIDTH, 16, FP16 activation width (1/5/10).
- ACC_WIDTH, 32, signed accumulator width.
- MAX_PREC, 8, maximum weight bits.
- LEN_WIDTH, 8, width of the vector-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a dot product; accepted only in IDLE.
- precision  in  4  weight bits P; latched at start.
- w_signed  in  1  1 = two's-complement weights, 0 = unsigned; latched at start.
- len  in  LEN_WIDTH  number of vectors; latched at start.
- exp_set  in  5  block exponent E_b; latched at start.
- acc_init  in  ACC_WIDTH  initial accumulator value; latched at start.
- in_valid  in  1  one weight bit-plane beat is present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- act  in  LANES*ACT_WIDTH  activation vector; sampled on bit-0 beat only.
- w  in  LANES  current weight bit per lane, LSB first.
- out_valid  out  1  result held.
- out_ready  in  1  result consumed.
- exp_out  out  5  E_b of the result.
- acc_out  out  ACC_WIDTH  result.
- ovf  out  1  sticky saturation flag for this dot product.
- nan_inf  out  1  sticky flag: an exponent-31 activation was seen.
- valid_fwd  out  1  in_valid && in_ready, registered.
- act_fwd  out  LANES*ACT_WIDTH  act, registered on each accepted beat.
- w_fwd  out  LANES  w, registered on each accepted beat.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; counters, flags and forwarding registers cleared. Reset mid-operation abandons the dot product with no output.
- Precision clamp: precision 0 is treated as 1; precision > MAX_PREC is treated as MAX_PREC.
- FSM states: IDLE, LOAD, ACCUM, DONE.
  - IDLE: start latches all config and sets acc = acc_init, ovf = nan_inf = 0. Goes to DONE if len == 0, else LOAD. start in any other state is ignored.
  - LOAD: in_ready = 1. Beat counter b runs 0..P-1. On beat 0 capture act. Per lane, partial product pp += sig << b, except at b == P-1 with w_signed, where pp −= sig << b. After beat P-1, go to ACCUM.
  - ACCUM: exactly one cycle, in_ready = 0. Add all lane terms plus acc, saturate, store. Vector counter++. Go to DONE if count == len, else LOAD.
  - DONE: out_valid = 1; acc_out, exp_out, ovf and nan_inf are held stable. Go to IDLE on out_ready.
- Per-lane arithmetic:
  - sig = (e != 0) ? {1, m} : {0, m} (11 bits).
  - ee = (e == 0) ? 1 : e.
  - prod = sig × W, signed, 11+MAX_PREC+1 bits; negated if the sign bit is set.
  - Alignment: if ee ≤ E_b, term = prod >>> (E_b − ee) (arithmetic, floor). If ee > E_b, term = prod << (ee − E_b), saturated to ACC_WIDTH.
  - If e == 31, term = 0 and nan_inf is set.
- Summation: sum in width ACC_WIDTH + clog2(LANES+1) + 1. Clamp to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]; set ovf on clamp or on any lane-term saturation.
- Scaling: with E_b = 15, one LSB = 2^-10 (e.g. 1.0 × 1 = 1024).
- Throughput: P+1 cycles per vector. Latency from the last beat to out_valid is 2 cycles.
- in_valid low during LOAD stalls; the beat counter holds.

Decomposition:
- Shared package fp_int_pkg: FP16 field widths and positions, EXP_NAN_INF = 31, state enum, and saturating-clamp width constants.
- One sub-module, fp_int_lane_term: per-lane bit-serial partial-product register plus align/sign/saturate. Instantiated LANES times.
- Adder tree, FSM and forwarding stay in the top.

Test Plan:
1. Signed, LANES=4, P=4, E_b=15, acts 0x3C00 ×4, weights 3, −2, 5, 1, len=1, acc_init=0 -> acc_out = 7168, ovf = 0, out_valid 2 cycles after beat 3.
2. Signed, P=4, E_b=15, lane acts 0x4000, 0x3800, 0x0000, 0x0000, all weights 1 -> acc_out = 2048 + 512 = 2560.
3. Weight bits 1111, act 0x3C00 in lane 0, other lanes 0 -> unsigned gives 15360; signed gives −1024.
4. ACC_WIDTH=16, acc_init = 0x7F00, one term of 1024 -> acc_out = 0x7FFF, ovf = 1.
5. Lane-0 act 0x7E00, lane-1 act 0x3C00, weights 1 -> acc_out = 1024, nan_inf = 1.
6. Reset mid-LOAD, then start with len=0 and acc_init = 5 -> out_valid one cycle later, acc_out = 5. Check valid_fwd/act_fwd lag accepted beats by exactly 1 cycle. A stall with in_valid = 0 mid-vector changes no result.
